// File: rtl/musicbox_sdram_pkg.sv
// Shared types and helpers for the MusicBox SDRAM access path.
// Provides the arbiter state type, SDRAM widths and a round-robin pick.
package musicbox_sdram_pkg;

    localparam int SDRAM_ADDR_W = 25;
    localparam int SDRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_READ
    } arb_state_t;

    // First set bit of req searching upward from last+1 with wrap over
    // n entries (n in 2..8). Returns last when nothing is set.
    function automatic logic [2:0] rr_pick(
        input logic [7:0]  req,
        input logic [2:0]  last,
        input int unsigned n
    );
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= 8; k++) begin
            idx = (32'(last) + k) % n;
            if (k <= n && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: rotate past last_i, find first set.
// Ports: req_i request vector, last_i previous winner, idx_o/any_o result.
module rr_priority_picker
    import musicbox_sdram_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [2:0] pick;

    assign pick  = rr_pick(8'(req_i), 3'(last_i), NUM_REQ);
    assign idx_o = IDX_W'(pick);
    assign any_o = |req_i;

endmodule

// File: rtl/sdram_access_arbiter.sv
// Round-robin sequencer sharing one SDRAM command port among NUM_REQ users.
// Ports: req_* per-requester command/grant/done, sdram_* controller side.
// Optional SDRAM_ARB_TIMEOUT_EN: read-data watchdog driving req_error.
module sdram_access_arbiter
    import musicbox_sdram_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = SDRAM_ADDR_W,
    parameter int DATA_W         = SDRAM_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock_50Mhz,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_isWriting,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writeData,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [DATA_W-1:0]         req_readData,
    output logic                      req_error,
    output logic [ADDR_W-1:0]         sdram_inputAddress,
    output logic [DATA_W-1:0]         sdram_writeData,
    output logic                      sdram_isWriting,
    output logic                      sdram_inputValid,
    input  logic [DATA_W-1:0]         sdram_readData,
    input  logic                      sdram_outputValid,
    input  logic                      sdram_recievedCommand,
    input  logic                      sdram_isBusy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("sdram_access_arbiter: parameter out of range");
    end

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q, wr_d;
    logic                valid_q, valid_d;
    logic [IDX_W-1:0]    pick;
    logic                any_req;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
`endif

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_valid),
        .last_i  (last_q),
        .idx_o   (pick),
        .any_o   (any_req)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = '0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        valid_d = valid_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                // The cycle carrying req_done is a mandatory gap so the
                // finished owner can drop req_valid before re-arbitration.
                if (!sdram_isBusy && any_req && ~|done_q) begin
                    addr_d        = req_address[int'(pick)*ADDR_W +: ADDR_W];
                    wdata_d       = req_writeData[int'(pick)*DATA_W +: DATA_W];
                    wr_d          = req_isWriting[pick];
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    valid_d       = 1'b1;
                    last_d        = pick;
                    state_d       = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (sdram_recievedCommand) begin
                    valid_d = 1'b0;
                    if (wr_q) begin
                        done_d  = grant_q;
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end else if (sdram_outputValid) begin
                        rdata_d = sdram_readData;
                        done_d  = grant_q;
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end else begin
                        state_d = ARB_WAIT_READ;
`ifdef SDRAM_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ARB_WAIT_READ: begin
                if (sdram_outputValid) begin
                    rdata_d = sdram_readData;
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    done_d  = grant_q;
                    err_d   = 1'b1;
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            last_q  <= IDX_W'(NUM_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            valid_q <= valid_d;
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign req_error = err_q;
`else
    assign req_error = 1'b0;
`endif

    assign req_grant          = grant_q;
    assign req_done           = done_q;
    assign req_readData       = rdata_q;
    assign sdram_inputAddress = addr_q;
    assign sdram_writeData    = wdata_q;
    assign sdram_isWriting    = wr_q;
    assign sdram_inputValid   = valid_q;

endmodule
